hamming_dec_arbiter: RTL and testbench
======================================

Name: hamming_dec_arbiter

Overview:
Round-robin arbiter/scheduler that shares one hamming_decoder instance between up to NUM_REQ requesters. It accepts 7-bit codewords through per-requester valid/ready handshakes and issues at most one word per cycle to the decoder. A tag pipeline matched to the decoder latency returns each decoded nibble and syndrome to the originating requester ID. It also keeps per-requester saturating counts of corrected errors.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of requester ID; must be >= clog2(NUM_REQ)
DEC_LAT, 1, decoder clock-cycle latency from dec_data sample to valid err_bits/out_data
CNT_W, 8, width of each per-requester error counter

Ports:
clk_arb  in  1  clock; all state updates on rising edge
rst_arb  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  requester i has a codeword pending
req_data  in  7*NUM_REQ  codeword of requester i in slice [7*i+6:7*i]
req_ready  out  NUM_REQ  one-hot grant; word i accepted when req_valid[i] & req_ready[i]
dec_data  out  7  codeword to decoder
dec_err_bits  in  3  decoder syndrome
dec_out_data  in  4  decoder corrected data nibble
clr_cnt  in  1  synchronous clear of all error counters
rsp_valid  out  1  one-cycle pulse, response valid
rsp_id  out  ID_W  requester ID of response
rsp_data  out  4  decoded data nibble
rsp_err  out  3  syndrome; 0 = no error
rsp_corrected  out  1  rsp_err != 0
err_cnt  out  CNT_W*NUM_REQ  per-requester corrected-error counters, slice i

Behaviour:
- Reset (rst_arb=1 at an edge): priority pointer=0; dec_data=0; tag pipeline flushed; rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, rsp_corrected=0; all err_cnt=0. In-flight words are dropped and produce no response. req_ready=0 during any cycle rst_arb is high.
- Arbitration is combinational from req_valid and the pointer. Grant goes to the first i with req_valid[i]=1, searching from the pointer upward with wrap at NUM_REQ. At most one grant per cycle. req_ready is 0 for every requester when none is valid.
- Pointer update on a grant to i: pointer <= (i+1) mod NUM_REQ. With no grant, the pointer holds.
- Issue: a grant in cycle t registers dec_data <= req_data slice i for cycle t+1. With no grant, dec_data <= 7'b0 (a valid codeword, so the decoder sees a clean input).
- Tag pipeline is DEC_LAT+1 stages of {valid,id}. Stage 0 is loaded in cycle t with {grant_any, i}.
- Response: when the last stage is valid, register rsp_data <= dec_out_data, rsp_err <= dec_err_bits, rsp_id <= tag id, and rsp_corrected. rsp_valid is high in cycle t+2+DEC_LAT, which is 3 cycles for DEC_LAT=1. rsp_valid is a pulse with no backpressure. When rsp_valid=0, the other rsp_* outputs hold their last values.
- Throughput: one word per cycle sustained. Back-to-back responses follow issue order.
- Counters: on a registered response with rsp_corrected=1, err_cnt[rsp_id] increments by 1 and saturates at 2^CNT_W-1 (no wrap). The increment is applied in the cycle after rsp_valid.
- clr_cnt: clears all counters at the edge. clr_cnt takes priority over a simultaneous increment, so the result is 0.
- req_data and req_valid of non-granted requesters are ignored. Dropping req_valid without a handshake is legal.

Optional Feature:
Macro HAMMING_ARB_LOCK_EN.
- Defined: adds input req_lock [NUM_REQ]. On a grant to i with req_lock[i]=1, the pointer stays at i, so i keeps top priority for the next cycle and can burst. With req_lock[i]=0, normal advance.
- Undefined: the port is absent and the pointer always advances.

Test Plan:
- Reset then idle, all req_valid=0 for 10 cycles -> req_ready=0, dec_data=7'b0, rsp_valid=0, err_cnt all 0.
- req_valid=4'b0001, req_data[0]=7'b0000111 (valid codeword), DEC_LAT=1 -> req_ready=4'b0001 in cycle t. In cycle t+3: rsp_valid=1, rsp_id=0, rsp_err=3'b000, rsp_corrected=0, err_cnt[0]=0.
- req_valid=4'b0010, req_data[1]=7'b1000111 (single-bit error) -> rsp_id=1, rsp_corrected=1, rsp_err nonzero, rsp_data equals the nibble for 7'b0000111; err_cnt[1]=1 one cycle later.
- req_valid=4'b1111 held for 8 cycles -> grants 0,1,2,3,0,1,2,3. Eight rsp_valid pulses arrive in the same ID order, starting 3 cycles after the first grant.
- Drive 260 erroneous words from requester 2 with CNT_W=8 -> err_cnt[2] saturates at 255. clr_cnt asserted in the same cycle as an increment -> err_cnt[2]=0.
- Assert rst_arb with 2 words in flight -> no rsp_valid pulses follow, pointer=0, and the next grant with req_valid=4'b1100 goes to requester 2.

Source files
------------

// File: rtl/hamming_dec_arbiter.sv
// rtl/hamming_dec_arbiter.sv - round-robin arbiter sharing one Hamming(7,4) decoder; HAMMING_ARB_LOCK_EN adds req_lock
module hamming_dec_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int DEC_LAT = 1,
    parameter int CNT_W   = 8
) (
    input  logic                     clk_arb,
    input  logic                     rst_arb,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [7*NUM_REQ-1:0]     req_data,
`ifdef HAMMING_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]       req_lock,
`endif
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [6:0]               dec_data,
    input  logic [2:0]               dec_err_bits,
    input  logic [3:0]               dec_out_data,
    input  logic                     clr_cnt,
    output logic                     rsp_valid,
    output logic [ID_W-1:0]          rsp_id,
    output logic [3:0]               rsp_data,
    output logic [2:0]               rsp_err,
    output logic                     rsp_corrected,
    output logic [CNT_W*NUM_REQ-1:0] err_cnt
);

    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  ptr_next;
    logic [ID_W-1:0]  grant_id;
    logic             grant_any;
    logic [6:0]       grant_word;
    logic [DEC_LAT:0] tag_valid;
    logic [ID_W-1:0]  tag_id [DEC_LAT+1];
    logic [CNT_W-1:0] cnt [NUM_REQ];

    // Two passes: requesters at/above the pointer first, then the wrapped-around ones.
    always_comb begin
        grant_any  = 1'b0;
        grant_id   = '0;
        grant_word = 7'b0;
        req_ready  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!rst_arb && !grant_any && req_valid[i] && (ID_W'(i) >= ptr)) begin
                grant_any    = 1'b1;
                grant_id     = ID_W'(i);
                grant_word   = req_data[7*i +: 7];
                req_ready[i] = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!rst_arb && !grant_any && req_valid[i]) begin
                grant_any    = 1'b1;
                grant_id     = ID_W'(i);
                grant_word   = req_data[7*i +: 7];
                req_ready[i] = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_next = ptr;
        if (grant_any) begin
            ptr_next = (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
`ifdef HAMMING_ARB_LOCK_EN
            if (req_lock[grant_id]) begin
                ptr_next = grant_id;
            end
`endif
        end
    end

    always_ff @(posedge clk_arb) begin
        if (rst_arb) begin
            ptr           <= '0;
            dec_data      <= 7'b0;
            tag_valid     <= '0;
            rsp_valid     <= 1'b0;
            rsp_id        <= '0;
            rsp_data      <= 4'b0;
            rsp_err       <= 3'b0;
            rsp_corrected <= 1'b0;
        end else begin
            ptr          <= ptr_next;
            dec_data     <= grant_word;
            tag_valid[0] <= grant_any;
            tag_id[0]    <= grant_id;
            for (int s = 1; s <= DEC_LAT; s++) begin
                tag_valid[s] <= tag_valid[s-1];
                tag_id[s]    <= tag_id[s-1];
            end
            rsp_valid <= tag_valid[DEC_LAT];
            if (tag_valid[DEC_LAT]) begin
                rsp_id        <= tag_id[DEC_LAT];
                rsp_data      <= dec_out_data;
                rsp_err       <= dec_err_bits;
                rsp_corrected <= (dec_err_bits != 3'b0);
            end
        end
    end

    always_ff @(posedge clk_arb) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rst_arb || clr_cnt) begin
                cnt[i] <= '0;
            end else if (rsp_valid && rsp_corrected && (rsp_id == ID_W'(i)) && (cnt[i] != {CNT_W{1'b1}})) begin
                cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    always_comb begin
        err_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            err_cnt[CNT_W*i +: CNT_W] = cnt[i];
        end
    end

endmodule

// File: tb/tb_hamming_dec_arbiter.sv
// tb/tb_hamming_dec_arbiter.sv - self-checking bench for hamming_dec_arbiter
module tb_hamming_dec_arbiter;

    localparam int N  = 4;
    localparam int CW = 8;

    logic           clk = 1'b0;
    logic           rst_arb = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [7*N-1:0] req_data = '0;
    logic [N-1:0]   req_lock = '0;
    logic [N-1:0]   req_ready;
    logic [6:0]     dec_data;
    logic [2:0]     dec_err_bits = 3'b0;
    logic [3:0]     dec_out_data = 4'b0;
    logic           clr_cnt = 1'b0;
    logic           rsp_valid;
    logic [1:0]     rsp_id;
    logic [3:0]     rsp_data;
    logic [2:0]     rsp_err;
    logic           rsp_corrected;
    logic [CW*N-1:0] err_cnt;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    hamming_dec_arbiter #(.NUM_REQ(N), .ID_W(2), .DEC_LAT(1), .CNT_W(CW)) dut (
        .clk_arb(clk),
        .rst_arb(rst_arb),
        .req_valid(req_valid),
        .req_data(req_data),
`ifdef HAMMING_ARB_LOCK_EN
        .req_lock(req_lock),
`endif
        .req_ready(req_ready),
        .dec_data(dec_data),
        .dec_err_bits(dec_err_bits),
        .dec_out_data(dec_out_data),
        .clr_cnt(clr_cnt),
        .rsp_valid(rsp_valid),
        .rsp_id(rsp_id),
        .rsp_data(rsp_data),
        .rsp_err(rsp_err),
        .rsp_corrected(rsp_corrected),
        .err_cnt(err_cnt)
    );

    // Hamming(7,4): bit p-1 holds position p; syndrome is the XOR of set positions.
    function automatic logic [2:0] syn(input logic [6:0] cw);
        int s = 0;
        for (int p = 1; p <= 7; p++) if (cw[p-1]) s ^= p;
        return 3'(s);
    endfunction

    function automatic logic [3:0] dat(input logic [6:0] cw);
        logic [6:0] c = cw;
        int si = int'(syn(cw));
        if (si != 0) c[si-1] = ~c[si-1];
        return {c[6], c[5], c[4], c[2]};
    endfunction

    function automatic logic [6:0] enc(input logic [3:0] d);
        logic [6:0] c = '0;
        logic [2:0] s;
        c[2] = d[0]; c[4] = d[1]; c[5] = d[2]; c[6] = d[3];
        s = syn(c);
        c[0] = s[0]; c[1] = s[1]; c[3] = s[2];
        return c;
    endfunction

    function automatic logic [6:0] rand_word(input bit with_err);
        logic [6:0] w = enc(4'($urandom));
        if (with_err) w[$urandom_range(0, 6)] ^= 1'b1;
        return w;
    endfunction

    // Stand-in decoder with one cycle of latency.
    always @(posedge clk) begin
        dec_err_bits <= syn(dec_data);
        dec_out_data <= dat(dec_data);
    end

    typedef struct {
        int         id;
        logic [3:0] d;
        logic [2:0] e;
        int         due;
    } exp_t;

    exp_t       exp_q[$];
    int         cyc = 0;
    int         mptr = 0;
    int         mcnt[N];
    logic       m_rsp_valid = 1'b0;
    logic [1:0] m_rsp_id = '0;
    logic [3:0] m_rsp_data = '0;
    logic [2:0] m_rsp_err = '0;
    logic [6:0] m_dec = '0;

    function automatic int model_grant();
        if (rst_arb) return -1;
        for (int k = 0; k < N; k++) if (req_valid[(mptr + k) % N]) return (mptr + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ready();
        int g = model_grant();
        logic [N-1:0] r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    function automatic logic [CW*N-1:0] model_cnt();
        logic [CW*N-1:0] r = '0;
        for (int i = 0; i < N; i++) r[CW*i +: CW] = CW'(mcnt[i]);
        return r;
    endfunction

    // Advances one clock, evolving the reference model from the inputs of the ending cycle.
    task automatic tick();
        int g = model_grant();
        logic was_rst = rst_arb;
        logic [6:0] w;
        if (was_rst) begin
            mptr = 0;
            exp_q.delete();
            for (int i = 0; i < N; i++) mcnt[i] = 0;
            m_dec = '0;
        end else begin
            if (clr_cnt) begin
                for (int i = 0; i < N; i++) mcnt[i] = 0;
            end else if (m_rsp_valid && m_rsp_err != 0 && mcnt[m_rsp_id] < (1 << CW) - 1) begin
                mcnt[m_rsp_id]++;
            end
            m_dec = '0;
            if (g >= 0) begin
                w = req_data[7*g +: 7];
                m_dec = w;
                exp_q.push_back('{id: g, d: dat(w), e: syn(w), due: cyc + 3});
                mptr = (g + 1) % N;
            end
        end
        @(posedge clk);
        cyc++;
        m_rsp_valid = 1'b0;
        if (was_rst) begin
            m_rsp_id = '0; m_rsp_data = '0; m_rsp_err = '0;
        end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            m_rsp_valid = 1'b1;
            m_rsp_id    = 2'(exp_q[0].id);
            m_rsp_data  = exp_q[0].d;
            m_rsp_err   = exp_q[0].e;
            void'(exp_q.pop_front());
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_arb = 1'b1;
        req_valid = 4'b1111;
        req_data = {4{7'b0000111}};
        #1;
        checks++; if (req_ready !== 4'b0000) $display("FAIL reset_ready_gated got=%b exp=0000", req_ready); else passed++;
        tick(); tick();
        rst_arb = 1'b0;
        req_valid = '0;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++; if (req_ready !== 4'b0) $display("FAIL idle_ready got=%b exp=0000", req_ready); else passed++;
            checks++; if (dec_data !== 7'b0) $display("FAIL idle_dec_data got=%b exp=0000000", dec_data); else passed++;
            checks++; if (rsp_valid !== 1'b0) $display("FAIL idle_rsp_valid got=%b exp=0", rsp_valid); else passed++;
            checks++; if (err_cnt !== '0) $display("FAIL idle_err_cnt got=%h exp=0", err_cnt); else passed++;
            tick();
        end
        checks++;
        if ({rsp_id, rsp_data, rsp_err, rsp_corrected} !== 10'b0)
            $display("FAIL reset_rsp_fields got=%b exp=0", {rsp_id, rsp_data, rsp_err, rsp_corrected});
        else passed++;
    endtask

    task automatic test_single_clean();
        req_valid = 4'b0001;
        req_data[6:0] = 7'b0000111;
        #1;
        checks++; if (req_ready !== 4'b0001) $display("FAIL clean_ready got=%b exp=0001", req_ready); else passed++;
        tick();
        req_valid = '0;
        tick();
        checks++; if (rsp_valid !== 1'b0) $display("FAIL clean_early_rsp got=%b exp=0", rsp_valid); else passed++;
        tick();
        checks++; if (rsp_valid !== 1'b1) $display("FAIL clean_rsp_valid got=%b exp=1", rsp_valid); else passed++;
        checks++; if (rsp_id !== 2'd0) $display("FAIL clean_rsp_id got=%0d exp=0", rsp_id); else passed++;
        checks++; if (rsp_err !== 3'b000) $display("FAIL clean_rsp_err got=%b exp=000", rsp_err); else passed++;
        checks++; if (rsp_corrected !== 1'b0) $display("FAIL clean_rsp_corrected got=%b exp=0", rsp_corrected); else passed++;
        checks++; if (rsp_data !== 4'b0001) $display("FAIL clean_rsp_data got=%b exp=0001", rsp_data); else passed++;
        tick();
        checks++; if (rsp_valid !== 1'b0) $display("FAIL clean_pulse_width got=%b exp=0", rsp_valid); else passed++;
        checks++; if (err_cnt[7:0] !== 8'd0) $display("FAIL clean_err_cnt0 got=%0d exp=0", err_cnt[7:0]); else passed++;
    endtask

    task automatic test_single_error();
        req_valid = 4'b0010;
        req_data[13:7] = 7'b1000111;
        #1;
        checks++; if (req_ready !== 4'b0010) $display("FAIL err_ready got=%b exp=0010", req_ready); else passed++;
        tick();
        req_valid = '0;
        tick(); tick();
        checks++; if (rsp_valid !== 1'b1) $display("FAIL err_rsp_valid got=%b exp=1", rsp_valid); else passed++;
        checks++; if (rsp_id !== 2'd1) $display("FAIL err_rsp_id got=%0d exp=1", rsp_id); else passed++;
        checks++; if (rsp_corrected !== 1'b1) $display("FAIL err_rsp_corrected got=%b exp=1", rsp_corrected); else passed++;
        checks++; if (rsp_err !== 3'd7) $display("FAIL err_rsp_err got=%b exp=111", rsp_err); else passed++;
        checks++; if (rsp_data !== 4'b0001) $display("FAIL err_rsp_data got=%b exp=0001", rsp_data); else passed++;
        checks++; if (err_cnt[15:8] !== 8'd0) $display("FAIL err_cnt1_early got=%0d exp=0", err_cnt[15:8]); else passed++;
        tick();
        checks++; if (err_cnt[15:8] !== 8'd1) $display("FAIL err_cnt1 got=%0d exp=1", err_cnt[15:8]); else passed++;
    endtask

    task automatic test_back_to_back();
        int t0;
        int pulses = 0;
        rst_arb = 1'b1;
        tick();
        rst_arb = 1'b0;
        t0 = cyc;
        for (int k = 0; k < 14; k++) begin
            req_valid = (k < 8) ? 4'b1111 : 4'b0000;
            for (int i = 0; i < N; i++) req_data[7*i +: 7] = rand_word($urandom_range(0, 1) == 1);
            #1;
            if (k < 8) begin
                checks++;
                if (req_ready !== 4'(1 << (k % 4))) $display("FAIL rr_grant k=%0d got=%b exp=%b", k, req_ready, 4'(1 << (k % 4)));
                else passed++;
            end
            if (rsp_valid === 1'b1) begin
                if (pulses == 0) begin
                    checks++; if (cyc !== t0 + 3) $display("FAIL rr_first_latency got=%0d exp=%0d", cyc - t0, 3); else passed++;
                end
                checks++; if (rsp_id !== 2'(pulses % 4)) $display("FAIL rr_rsp_order n=%0d got=%0d exp=%0d", pulses, rsp_id, pulses % 4); else passed++;
                pulses++;
            end
            checks++;
            if ({rsp_valid, rsp_id, rsp_data, rsp_err, rsp_corrected} !== {m_rsp_valid, m_rsp_id, m_rsp_data, m_rsp_err, m_rsp_err != 3'b0})
                $display("FAIL rr_rsp cyc=%0d got=%b exp=%b", cyc, {rsp_valid, rsp_id, rsp_data, rsp_err, rsp_corrected},
                         {m_rsp_valid, m_rsp_id, m_rsp_data, m_rsp_err, m_rsp_err != 3'b0});
            else passed++;
            checks++; if (err_cnt !== model_cnt()) $display("FAIL rr_err_cnt got=%h exp=%h", err_cnt, model_cnt()); else passed++;
            tick();
        end
        checks++; if (pulses !== 8) $display("FAIL rr_pulse_count got=%0d exp=8", pulses); else passed++;
    endtask

    task automatic test_saturation();
        rst_arb = 1'b1;
        tick();
        rst_arb = 1'b0;
        for (int k = 0; k < 264; k++) begin
            req_valid = (k < 260) ? 4'b0100 : 4'b0000;
            req_data[20:14] = rand_word(1'b1);
            #1;
            checks++; if (err_cnt !== model_cnt()) $display("FAIL sat_err_cnt k=%0d got=%h exp=%h", k, err_cnt, model_cnt()); else passed++;
            tick();
        end
        checks++; if (err_cnt[23:16] !== 8'd255) $display("FAIL sat_value got=%0d exp=255", err_cnt[23:16]); else passed++;
        req_valid = 4'b0100;
        req_data[20:14] = 7'b1000111;
        tick();
        req_valid = '0;
        tick(); tick();
        clr_cnt = 1'b1;
        #1;
        checks++; if ({rsp_valid, rsp_corrected} !== 2'b11) $display("FAIL clr_pre_rsp got=%b exp=11", {rsp_valid, rsp_corrected}); else passed++;
        tick();
        clr_cnt = 1'b0;
        #1;
        checks++; if (err_cnt[23:16] !== 8'd0) $display("FAIL clr_priority got=%0d exp=0", err_cnt[23:16]); else passed++;
        checks++; if (err_cnt !== model_cnt()) $display("FAIL clr_all got=%h exp=%h", err_cnt, model_cnt()); else passed++;
    endtask

    task automatic test_reset_inflight();
        req_valid = 4'b0011;
        req_data[6:0]  = enc(4'h5);
        req_data[13:7] = enc(4'hA);
        tick(); tick();
        rst_arb = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0) $display("FAIL rstf_ready got=%b exp=0000", req_ready); else passed++;
        tick();
        rst_arb = 1'b0;
        req_valid = '0;
        #1;
        checks++; if (dec_data !== 7'b0) $display("FAIL rstf_dec_data got=%b exp=0", dec_data); else passed++;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++; if (rsp_valid !== 1'b0) $display("FAIL rstf_no_rsp i=%0d got=%b exp=0", i, rsp_valid); else passed++;
            tick();
        end
        req_valid = 4'b1100;
        #1;
        checks++; if (req_ready !== 4'b0100) $display("FAIL rstf_next_grant got=%b exp=0100", req_ready); else passed++;
        tick();
        req_valid = '0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 320; k++) begin
            if (k < 310) begin
                req_valid = 4'($urandom);
                for (int i = 0; i < N; i++) req_data[7*i +: 7] = rand_word($urandom_range(0, 1) == 1);
                clr_cnt = ($urandom_range(0, 19) == 0);
                rst_arb = ($urandom_range(0, 149) == 0);
            end else begin
                req_valid = '0;
                clr_cnt = 1'b0;
                rst_arb = 1'b0;
            end
            #1;
            checks++; if (req_ready !== model_ready()) $display("FAIL rnd_ready k=%0d got=%b exp=%b", k, req_ready, model_ready()); else passed++;
            checks++; if (dec_data !== m_dec) $display("FAIL rnd_dec_data k=%0d got=%b exp=%b", k, dec_data, m_dec); else passed++;
            checks++;
            if ({rsp_valid, rsp_id, rsp_data, rsp_err, rsp_corrected} !== {m_rsp_valid, m_rsp_id, m_rsp_data, m_rsp_err, m_rsp_err != 3'b0})
                $display("FAIL rnd_rsp k=%0d got=%b exp=%b", k, {rsp_valid, rsp_id, rsp_data, rsp_err, rsp_corrected},
                         {m_rsp_valid, m_rsp_id, m_rsp_data, m_rsp_err, m_rsp_err != 3'b0});
            else passed++;
            checks++; if (err_cnt !== model_cnt()) $display("FAIL rnd_err_cnt k=%0d got=%h exp=%h", k, err_cnt, model_cnt()); else passed++;
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) mcnt[i] = 0;
        @(negedge clk);
        test_reset();
        test_single_clean();
        test_single_error();
        test_back_to_back();
        test_saturation();
        test_reset_inflight();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
